// File: rtl/paddle_ctrl.sv
// paddle_ctrl: owns both paddle positions and updates them once per frame.
// Raw buttons are synchronized, then a single clamp/step datapath is shared
// between the players: P1 in the UPD1 slot, P2 in the UPD2 slot.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame_tick; positions frozen
// UPD1  | shared datapath applies the move rule to player 1
// UPD2  | shared datapath applies the move rule to player 2
// DONE  | both paddles updated; update_done is high for this cycle
module paddle_ctrl #(
    parameter int VS          = 480,
    parameter int HEIGHT      = 120,
    parameter int STEP        = 20,
    parameter int RESET_Y     = 180,
    parameter int HOLD_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       P1_up,
    input  logic       P1_down,
    input  logic       P2_up,
    input  logic       P2_down,
    output logic [9:0] P1_paddle_y,
    output logic [9:0] P2_paddle_y,
    output logic       busy,
    output logic       update_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_UPD1 = 2'd1;
    localparam logic [1:0] S_UPD2 = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [10:0] C_VS      = 11'(VS);
    localparam logic [10:0] C_HEIGHT  = 11'(HEIGHT);
    localparam logic [10:0] C_STEP    = 11'(STEP);
    localparam logic [10:0] C_LIMIT   = 11'(VS - HEIGHT);
    localparam logic [9:0]  C_RESET_Y = 10'(RESET_Y);
    localparam logic [2:0]  C_HOLD    = 3'(HOLD_FRAMES);

    // Button vector layout: {P2_down, P2_up, P1_down, P1_up}
    logic [3:0] w_btn_raw;
    logic [3:0] r_btn_meta;
    logic [3:0] r_btn_sync;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_busy;
    logic       r_update_done;

    logic [9:0] r_p1_y;
    logic [9:0] r_p2_y;
    logic [2:0] r_p1_hold;
    logic [2:0] r_p2_hold;
    logic       r_p1_last;   // 1 = last accepted move was down
    logic       r_p2_last;

    // Shared datapath operands, selected by which update slot is active
    logic        w_slot_p2;
    logic [9:0]  w_y;
    logic        w_up;
    logic        w_dn;
    logic [2:0]  w_hold;
    logic        w_last;

    logic        w_move;
    logic [2:0]  w_hold_nxt;
    logic        w_last_nxt;

    logic [10:0] w_y_ext;
    logic [10:0] w_down_sum;
    logic [10:0] w_down_y;
    logic [10:0] w_up_y;
    logic [9:0]  w_y_nxt;

    assign w_btn_raw = {P2_down, P2_up, P1_down, P1_up};

    // Two-flop synchronizer on every raw button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_meta <= 4'b0000;
            r_btn_sync <= 4'b0000;
        end else begin
            r_btn_meta <= w_btn_raw;
            r_btn_sync <= r_btn_meta;
        end
    end

    // Frame sequencing; ticks seen outside IDLE are dropped, not queued
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (frame_tick) w_state_nxt = S_UPD1;
            S_UPD1:  w_state_nxt = S_UPD2;
            S_UPD2:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus registered busy/update_done decoded from next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_update_done <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_update_done <= (w_state_nxt == S_DONE);
        end
    end

    assign w_slot_p2 = (r_state == S_UPD2);
    assign w_y       = w_slot_p2 ? r_p2_y        : r_p1_y;
    assign w_up      = w_slot_p2 ? r_btn_sync[2] : r_btn_sync[0];
    assign w_dn      = w_slot_p2 ? r_btn_sync[3] : r_btn_sync[1];
    assign w_hold    = w_slot_p2 ? r_p2_hold     : r_p1_hold;
    assign w_last    = w_slot_p2 ? r_p2_last     : r_p1_last;

    // Press / auto-repeat decision for the player in the current slot
    always_comb begin
        w_move     = 1'b0;
        w_hold_nxt = w_hold;
        w_last_nxt = w_last;
        if (w_up == w_dn) begin
            w_hold_nxt = 3'd0;
        end else if ((w_hold == 3'd0) || (w_dn != w_last)) begin
            w_move     = 1'b1;
            w_hold_nxt = 3'd1;
            w_last_nxt = w_dn;
        end else if (w_hold < C_HOLD) begin
            w_hold_nxt = w_hold + 3'd1;
        end else begin
            w_move     = 1'b1;
        end
    end

    // Clamp/step in 11 bits so y+STEP+HEIGHT cannot wrap before the compare
    assign w_y_ext    = {1'b0, w_y};
    assign w_down_sum = w_y_ext + C_STEP + C_HEIGHT;
    assign w_down_y   = (w_down_sum <= C_VS) ? (w_y_ext + C_STEP) : C_LIMIT;
    assign w_up_y     = (w_y_ext >= C_STEP) ? (w_y_ext - C_STEP) : 11'd0;
    assign w_y_nxt    = !w_move ? w_y : (w_dn ? 10'(w_down_y) : 10'(w_up_y));

    // Per-player state only changes in its own slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p1_y    <= C_RESET_Y;
            r_p2_y    <= C_RESET_Y;
            r_p1_hold <= 3'd0;
            r_p2_hold <= 3'd0;
            r_p1_last <= 1'b0;
            r_p2_last <= 1'b0;
        end else begin
            if (r_state == S_UPD1) begin
                r_p1_y    <= w_y_nxt;
                r_p1_hold <= w_hold_nxt;
                r_p1_last <= w_last_nxt;
            end
            if (r_state == S_UPD2) begin
                r_p2_y    <= w_y_nxt;
                r_p2_hold <= w_hold_nxt;
                r_p2_last <= w_last_nxt;
            end
        end
    end

    assign P1_paddle_y = r_p1_y;
    assign P2_paddle_y = r_p2_y;
    assign busy        = r_busy;
    assign update_done = r_update_done;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: frame-level reference model feeds a scoreboard queue,
// a monitor pops it on every update_done pulse.
module tb_paddle_ctrl;

    localparam int VS          = 480;
    localparam int HEIGHT      = 120;
    localparam int STEP        = 20;
    localparam int RESET_Y     = 180;
    localparam int HOLD_FRAMES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       P1_up = 1'b0;
    logic       P1_down = 1'b0;
    logic       P2_up = 1'b0;
    logic       P2_down = 1'b0;
    logic [9:0] P1_paddle_y;
    logic [9:0] P2_paddle_y;
    logic       busy;
    logic       update_done;

    paddle_ctrl #(
        .VS(VS), .HEIGHT(HEIGHT), .STEP(STEP),
        .RESET_Y(RESET_Y), .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .P1_up(P1_up), .P1_down(P1_down), .P2_up(P2_up), .P2_down(P2_down),
        .P1_paddle_y(P1_paddle_y), .P2_paddle_y(P2_paddle_y),
        .busy(busy), .update_done(update_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_pulses = 0;
    int frames_run = 0;

    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    // Reference model: position plus length of the current same-direction run
    int exp_y[2];
    int run_len[2];
    int run_dir[2];   // 1 = up, 2 = down

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            exp_y[p]   = RESET_Y;
            run_len[p] = 0;
            run_dir[p] = 0;
        end
    endtask

    // A move happens on the first frame of a run and on every frame after
    // the run has lasted more than HOLD_FRAMES frames.
    task automatic model_frame(input logic [3:0] btn);
        bit u, d;
        int nd;
        for (int p = 0; p < 2; p++) begin
            u = btn[2*p];
            d = btn[2*p+1];
            if (u == d) begin
                run_len[p] = 0;
            end else begin
                nd = d ? 2 : 1;
                if (run_len[p] == 0 || nd != run_dir[p]) run_len[p] = 1;
                else if (run_len[p] < 1000) run_len[p]++;
                run_dir[p] = nd;
                if (run_len[p] == 1 || run_len[p] > HOLD_FRAMES) begin
                    if (d) exp_y[p] = (exp_y[p] + STEP > VS - HEIGHT) ? VS - HEIGHT : exp_y[p] + STEP;
                    else   exp_y[p] = (exp_y[p] < STEP) ? 0 : exp_y[p] - STEP;
                end
            end
        end
    endtask

    task automatic set_buttons(input logic [3:0] btn);
        P1_up   = btn[0];
        P1_down = btn[1];
        P2_up   = btn[2];
        P2_down = btn[3];
    endtask

    // One full frame: settle buttons, tick, check per-edge latency
    task automatic do_frame(input logic [3:0] btn, input bit extra_tick);
        int old1, old2;
        @(negedge clk);
        set_buttons(btn);
        repeat (3) @(negedge clk);
        old1 = exp_y[0];
        old2 = exp_y[1];
        model_frame(btn);
        exp_q.push_back({10'(exp_y[0]), 10'(exp_y[1])});
        frames_run++;
        frame_tick = 1'b1;
        @(negedge clk);                       // after edge k
        frame_tick = 1'b0;
        check("busy_rise", busy, 1);
        check("p1_hold_k", P1_paddle_y, old1);
        @(negedge clk);                       // after edge k+1
        if (extra_tick) frame_tick = 1'b1;
        check("p1_new_k1", P1_paddle_y, exp_y[0]);
        check("p2_hold_k1", P2_paddle_y, old2);
        @(negedge clk);                       // after edge k+2
        frame_tick = 1'b0;
        check("p2_new_k2", P2_paddle_y, exp_y[1]);
        check("done_k2", update_done, 1);
        @(negedge clk);                       // after edge k+3
        check("busy_fall", busy, 0);
        check("done_k3", update_done, 0);
        if (extra_tick) begin
            @(negedge clk);
            check("no_second_seq", busy, 0);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && update_done) begin
            done_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got pulse expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_p1", int'(P1_paddle_y), int'(mon_e[19:10]));
                check("sb_p2", int'(P2_paddle_y), int'(mon_e[9:0]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[7];
        logic [3:0] rb;
        int reps;
        int nframes;
        seq = '{160, 160, 160, 160, 140, 120, 100};
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_p1", P1_paddle_y, RESET_Y);
        check("rst_p2", P2_paddle_y, RESET_Y);
        check("rst_busy", busy, 0);
        check("rst_done", update_done, 0);
        reset = 1'b1;

        // Single press of P1 down
        do_frame(4'b0010, 0);
        check("single_p1", P1_paddle_y, 200);
        check("single_p2", P2_paddle_y, 180);
        do_frame(4'b0000, 0);

        // Auto-repeat on P2 up
        for (int i = 0; i < 7; i++) begin
            do_frame(4'b0100, 0);
            check("autorep_p2", P2_paddle_y, seq[i]);
        end
        do_frame(4'b0000, 0);

        // Clamping: P1 down to the floor, P2 up to the top
        for (int i = 0; i < 15; i++) do_frame(4'b0110, 0);
        check("clamp_p1_low", P1_paddle_y, VS - HEIGHT);
        check("clamp_p2_top", P2_paddle_y, 0);
        do_frame(4'b0000, 0);
        do_frame(4'b0100, 0);
        check("clamp_p2_press", P2_paddle_y, 0);

        // Both buttons clear the hold count
        do_frame(4'b0001, 0);
        check("up_first", P1_paddle_y, 340);
        do_frame(4'b0011, 0);
        check("both_nomove", P1_paddle_y, 340);
        do_frame(4'b0001, 0);
        check("up_after_both", P1_paddle_y, 320);

        // Direction change mid-hold
        do_frame(4'b0010, 0);
        check("dn_first", P1_paddle_y, 340);
        do_frame(4'b0010, 0);
        check("dn_held", P1_paddle_y, 340);
        do_frame(4'b0001, 0);
        check("dir_change", P1_paddle_y, 320);

        // Second tick while busy is ignored
        do_frame(4'b1000, 1);
        check("busy_tick_p2", P2_paddle_y, 20);

        // Reset in the middle of a frame
        @(negedge clk);
        set_buttons(4'b0010);
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_p1", P1_paddle_y, RESET_Y);
        check("midrst_p2", P2_paddle_y, RESET_Y);
        check("midrst_busy", busy, 0);
        check("midrst_done", update_done, 0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        do_frame(4'b0010, 0);
        check("post_rst_p1", P1_paddle_y, 200);
        check("post_rst_p2", P2_paddle_y, 180);

        // Randomized held patterns
        nframes = 0;
        while (nframes < 40) begin
            rb = 4'($urandom_range(0, 15));
            reps = $urandom_range(1, 7);
            for (int r = 0; r < reps; r++) begin
                do_frame(rb, 0);
                nframes++;
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drain", exp_q.size(), 0);
        check("done_count", done_pulses, frames_run);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
